// File: rtl/pps_mem_host.sv
// Target-side memory and run control for the 16-bit pipelined processor.
// Holds IM/DM, services processor reads/writes in RUN, handles load, launch, budget and readback.
module pps_mem_host #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int CYC_WIDTH  = 16,
  parameter int MAX_CYCLES = 60000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  ld_sel,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  go,
  input  logic                  clr,
  output logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  input  logic                  im_rd,
  output logic [DATA_WIDTH-1:0] im_r_data,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  input  logic                  rb_sel,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CYC_WIDTH-1:0]  cycles
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CYC_WIDTH-1:0] CYC_LAST = CYC_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CYC_WIDTH-1:0] CYC_MAX  = CYC_WIDTH'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    run_entry_s;
  logic                    timeout_hit_s;
  logic                    run_s;
  logic                    ld_wr_s;
  logic                    dm_we_s;
  logic [ADDR_WIDTH-1:0]   dm_wa_s;
  logic [DATA_WIDTH-1:0]   dm_wd_s;
  logic                    start_r;
  logic                    timeout_r;
  logic [CYC_WIDTH-1:0]    cycles_r;
  logic [DATA_WIDTH-1:0]   im_r_data_r;
  logic [DATA_WIDTH-1:0]   dm_r_data_r;
  logic [DATA_WIDTH-1:0]   rb_data_r;
  logic [DATA_WIDTH-1:0]   im_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   dm_mem [DEPTH];

  // Next-state logic; go wins over ld_valid and clr so a launch is never lost.
  always_comb begin
    state_nxt_s   = state_r;
    run_entry_s   = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (go) begin
          state_nxt_s = S_RUN;
          run_entry_s = 1'b1;
        end else if (ld_valid) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (go) begin
          state_nxt_s = S_RUN;
          run_entry_s = 1'b1;
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt_s = S_DONE;
        end else if (cycles_r == CYC_LAST) begin
          state_nxt_s   = S_DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        if (go) begin
          state_nxt_s = S_RUN;
          run_entry_s = 1'b1;
        end else if (clr) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Write-port steering: the loader and the processor never own DM in the same state.
  always_comb begin
    run_s    = (state_r == S_RUN);
    ld_ready = (state_r == S_IDLE) || (state_r == S_LOAD);
    ld_wr_s  = ld_valid && ld_ready;
    if (run_s) begin
      dm_we_s = dm_wr;
      dm_wa_s = dm_addr;
      dm_wd_s = dm_w_data;
    end else begin
      dm_we_s = ld_wr_s && ld_sel;
      dm_wa_s = ld_addr;
      dm_wd_s = ld_data;
    end
  end

  // Control registers: state, start pulse, timeout flag and saturating cycle counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      start_r   <= 1'b0;
      timeout_r <= 1'b0;
      cycles_r  <= {CYC_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      start_r <= run_entry_s;
      if (run_entry_s) begin
        timeout_r <= 1'b0;
        cycles_r  <= {CYC_WIDTH{1'b0}};
      end else if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end else if (run_s && (state_nxt_s == S_RUN) && (cycles_r != CYC_MAX)) begin
        cycles_r <= cycles_r + {{(CYC_WIDTH-1){1'b0}}, 1'b1};
      end else if ((state_r == S_DONE) && (state_nxt_s == S_IDLE)) begin
        timeout_r <= 1'b0;
      end else begin
        cycles_r <= cycles_r;
      end
    end
  end

  // Memory arrays survive reset; writes are only blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (ld_wr_s && !ld_sel) begin
        im_mem[ld_addr] <= ld_data;
      end
      if (dm_we_s) begin
        dm_mem[dm_wa_s] <= dm_wd_s;
      end
    end
  end

  // Registered read ports; a same-cycle DM read and write returns the old word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      im_r_data_r <= {DATA_WIDTH{1'b0}};
      dm_r_data_r <= {DATA_WIDTH{1'b0}};
      rb_data_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      if (run_s && im_rd) begin
        im_r_data_r <= im_mem[im_addr];
      end
      if (run_s && dm_rd) begin
        dm_r_data_r <= dm_mem[dm_addr];
      end
      if (!run_s) begin
        rb_data_r <= rb_sel ? dm_mem[rb_addr] : im_mem[rb_addr];
      end
    end
  end

  assign start     = start_r;
  assign busy      = (state_r == S_RUN);
  assign done      = (state_r == S_DONE);
  assign timeout   = timeout_r;
  assign cycles    = cycles_r;
  assign im_r_data = im_r_data_r;
  assign dm_r_data = dm_r_data_r;
  assign rb_data   = rb_data_r;

endmodule

// File: tb/tb_pps_mem_host.sv
// Directed bench for pps_mem_host: load, run, DM hazards, stop, budget timeout, reset and readback.
module tb_pps_mem_host;
  logic        clk = 1'b0;
  logic        rst, ld_valid, ld_ready, ld_sel, go, clr, start, stop;
  logic [7:0]  ld_addr, im_addr, dm_addr, rb_addr;
  logic [15:0] ld_data, im_r_data, dm_w_data, dm_r_data, rb_data, cycles;
  logic        im_rd, dm_rd, dm_wr, rb_sel, busy, done, timeout;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_ticks;

  pps_mem_host #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .CYC_WIDTH(16), .MAX_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .go(go), .clr(clr), .start(start), .stop(stop),
    .im_addr(im_addr), .im_rd(im_rd), .im_r_data(im_r_data), .dm_addr(dm_addr),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_w_data(dm_w_data), .dm_r_data(dm_r_data),
    .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [7:0] addr, input logic [15:0] data);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic readback(input logic sel, input logic [7:0] addr);
    rb_sel = sel; rb_addr = addr;
    tick();
  endtask

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = 8'h00; ld_data = 16'h0000;
    go = 1'b0; clr = 1'b0; stop = 1'b0; im_addr = 8'h00; im_rd = 1'b0;
    dm_addr = 8'h00; dm_rd = 1'b0; dm_wr = 1'b0; dm_w_data = 16'h0000;
    rb_sel = 1'b0; rb_addr = 8'h00;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_cycles", {16'd0, cycles}, 32'd0);
    check("rst_im_r", {16'd0, im_r_data}, 32'd0);
    check("rst_dm_r", {16'd0, dm_r_data}, 32'd0);
    check("rst_rb", {16'd0, rb_data}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    rst = 1'b1;

    // Test 1: program load, launch and first fetch
    load(1'b0, 8'h00, 16'hA001);
    load(1'b0, 8'h01, 16'hB002);
    load(1'b0, 8'h02, 16'hC003);
    load(1'b0, 8'h03, 16'hF000);
    load(1'b1, 8'h20, 16'h5555);
    readback(1'b0, 8'h02);
    check("load_rb_im2", {16'd0, rb_data}, 32'h0000C003);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("run_start", {31'd0, start}, 32'd1);
    check("run_busy", {31'd0, busy}, 32'd1);
    check("run_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("run_cyc0", {16'd0, cycles}, 32'd0);
    im_rd = 1'b1; im_addr = 8'h00;
    tick();
    check("start_one_cycle", {31'd0, start}, 32'd0);
    check("im_rd0", {16'd0, im_r_data}, 32'h0000A001);
    im_rd = 1'b0; im_addr = 8'h01;
    tick();
    check("im_hold", {16'd0, im_r_data}, 32'h0000A001);

    // Test 2 and 3: DM write/read and same-cycle read-old
    dm_wr = 1'b1; dm_addr = 8'h10; dm_w_data = 16'h1234;
    tick();
    dm_wr = 1'b0; dm_rd = 1'b1;
    tick();
    check("dm_rd_10", {16'd0, dm_r_data}, 32'h00001234);
    dm_addr = 8'h20; dm_wr = 1'b1; dm_w_data = 16'hAAAA;
    tick();
    check("dm_rw_old", {16'd0, dm_r_data}, 32'h00005555);
    dm_wr = 1'b0;
    tick();
    check("dm_rd_new", {16'd0, dm_r_data}, 32'h0000AAAA);
    dm_rd = 1'b0;
    check("run1_cyc6", {16'd0, cycles}, 32'd6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_done", {31'd0, done}, 32'd1);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_timeout", {31'd0, timeout}, 32'd0);
    check("stop_cycles", {16'd0, cycles}, 32'd6);
    readback(1'b1, 8'h10);
    check("done_rb_dm10", {16'd0, rb_data}, 32'h00001234);
    load(1'b1, 8'h10, 16'hFFFF);
    readback(1'b1, 8'h10);
    check("done_no_load", {16'd0, rb_data}, 32'h00001234);
    readback(1'b1, 8'h20);
    check("done_rb_dm20", {16'd0, rb_data}, 32'h0000AAAA);

    // Test 4: re-run from DONE, go ignored in RUN, stop after 37 cycles
    go = 1'b1;
    tick();
    go = 1'b0;
    check("rerun_start", {31'd0, start}, 32'd1);
    check("rerun_cyc0", {16'd0, cycles}, 32'd0);
    check("rerun_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 37; i++) begin
      go = (i == 10);
      tick();
    end
    go = 1'b0;
    check("rerun_cyc37", {16'd0, cycles}, 32'd37);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop37_done", {31'd0, done}, 32'd1);
    check("stop37_timeout", {31'd0, timeout}, 32'd0);
    check("stop37_cycles", {16'd0, cycles}, 32'd37);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_idle_done", {31'd0, done}, 32'd0);
    check("clr_ld_ready", {31'd0, ld_ready}, 32'd1);

    // Test 5: budget timeout with stop held low
    go = 1'b1;
    tick();
    go = 1'b0;
    n_ticks = 0;
    while (!done && n_ticks < 200) begin
      tick();
      n_ticks++;
    end
    check("to_ticks", n_ticks, 32'd100);
    check("to_timeout", {31'd0, timeout}, 32'd1);
    check("to_cycles", {16'd0, cycles}, 32'd99);

    // Test 6: reset in the middle of a run
    clr = 1'b1;
    tick();
    clr = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    im_rd = 1'b1; im_addr = 8'h02;
    tick();
    im_rd = 1'b0;
    check("r6_im2", {16'd0, im_r_data}, 32'h0000C003);
    rst = 1'b0;
    tick();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_start", {31'd0, start}, 32'd0);
    check("mid_rst_cycles", {16'd0, cycles}, 32'd0);
    check("mid_rst_im_r", {16'd0, im_r_data}, 32'd0);
    check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    rst = 1'b1;
    tick();
    check("post_rst_start", {31'd0, start}, 32'd0);
    readback(1'b0, 8'h03);
    check("post_rst_rb_im3", {16'd0, rb_data}, 32'h0000F000);
    readback(1'b1, 8'h10);
    check("post_rst_rb_dm10", {16'd0, rb_data}, 32'h00001234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
